// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Lets two requesters share one external ALU. Requests are arbitrated
//   round-robin and accepted with a valid/ready handshake. The winner's
//   operands and op are registered and held on the ALU inputs for LAT cycles.
//   The ALU result is then captured and returned through a per-requester
//   valid/ready response handshake.
//
// Parameters
//   W    datapath width of operands and result
//   OPW  ALU control code width
//   LAT  cycles the ALU inputs are held before the result is captured (1..15)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid / req_ready       per-requester request handshake (bit i = req i)
//   req_a0/1, req_b0/1, req_op0/1  operands and ALU control per requester
//   resp_valid / resp_ready     per-requester response handshake
//   resp_result/negative/err    captured result, Negative flag, error flag
//   alu_a, alu_b, alu_ctrl      operands and control driven to the shared ALU
//   alu_result, alu_negative    outputs coming back from the shared ALU
//   busy                        high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int W   = 19,
    parameter int OPW = 5,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_result,
    output logic           resp_negative,
    output logic           resp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_ctrl,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_negative,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]     CNT_INIT     = 4'(LAT - 1);
    localparam logic [OPW-1:0] OP_DIV       = OPW'(3);
    localparam logic [OPW-1:0] OP_FIRST_BAD = OPW'(10);

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;
    logic           grant_id;
    logic           grant;
    logic [3:0]     cnt;
    logic           pend_err;
    logic           accept;
    logic           capture;
    logic           release_resp;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [OPW-1:0] sel_op;
    logic           sel_err;

    // With both requesters valid, the one that was not served last wins;
    // otherwise whichever single requester is valid gets the grant.
    assign grant   = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign sel_a   = grant ? req_a1  : req_a0;
    assign sel_b   = grant ? req_b1  : req_b0;
    assign sel_op  = grant ? req_op1 : req_op0;
    assign sel_err = ((sel_op == OP_DIV) && (sel_b == '0)) || (sel_op >= OP_FIRST_BAD);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready is also gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_nxt    = state;
        req_ready    = 2'b00;
        resp_valid   = 2'b00;
        accept       = 1'b0;
        capture      = 1'b0;
        release_resp = 1'b0;
        case (state)
            IDLE: begin
                if ((req_valid != 2'b00) && rst_n) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = grant_id ? 2'b10 : 2'b01;
                if (resp_ready[grant_id]) begin
                    release_resp = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ALU input registers double as the operand latch. They are only
    // loaded on acceptance, so they stay put through EXEC and afterwards.
    // The error flag waits in pend_err until the result is captured, so all
    // response fields change together at the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctrl      <= '0;
            grant_id      <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= 4'd0;
            pend_err      <= 1'b0;
            resp_result   <= '0;
            resp_negative <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            if (accept) begin
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                alu_ctrl <= sel_op;
                grant_id <= grant;
                pend_err <= sel_err;
                cnt      <= CNT_INIT;
            end
            if ((state == EXEC) && !capture) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                resp_result   <= alu_result;
                resp_negative <= alu_negative;
                resp_err      <= pend_err;
            end
            if (release_resp) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule
